// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus (CDB) arbiter.
// Holds:
//   - the result packet broadcast on the CDB;
//   - the bus geometry;
//   - a wrap-around index helper used by the round-robin scan.
package cdb_arbiter_pkg;

  localparam int NUM_CDB_SRC = 4;   // ALU0, ALU1, LSU, BRU
  localparam int CDB_W       = 2;   // lanes broadcast per cycle
  localparam int PHYS_W      = 6;   // physical register tag width
  localparam int ROB_W       = 6;   // ROB tag width
  localparam int FIFO_DEPTH  = 2;   // result buffer entries per source (power of 2)
  localparam int SRC_W       = $clog2(NUM_CDB_SRC);
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    SRC_ALU0 = 2'd0,
    SRC_ALU1 = 2'd1,
    SRC_LSU  = 2'd2,
    SRC_BRU  = 2'd3
  } cdb_src_e;

  typedef struct packed {
    logic [PHYS_W-1:0] tag;
    logic [63:0]       value;
    logic [ROB_W-1:0]  rob_tag;
  } cdb_pkt_t;

  localparam cdb_pkt_t CDB_PKT_ZERO = '{
    tag:     {PHYS_W{1'b0}},
    value:   64'h0,
    rob_tag: {ROB_W{1'b0}}
  };

  // Source index 'off' positions after 'base', wrapping modulo NUM_CDB_SRC.
  function automatic logic [SRC_W-1:0] src_step(input logic [SRC_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return SRC_W'(sum % NUM_CDB_SRC);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Handshake and broadcast bundle of the CDB arbiter.
// Modports:
//   - master: the execution-unit side driving src_* and observing src_ready and cdb_*.
//   - slave:  the arbiter side.
// Signals:
//   src_valid/src_ready      per-source valid/ready handshake
//   src_tag/value/rob_tag    per-source result payload
//   cdb_valid                per-lane broadcast valid
//   cdb_tag/value/rob_tag    per-lane broadcast payload
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [NUM_CDB_SRC-1:0]             src_valid;
  logic [NUM_CDB_SRC-1:0]             src_ready;
  logic [NUM_CDB_SRC-1:0][PHYS_W-1:0] src_tag;
  logic [NUM_CDB_SRC-1:0][63:0]       src_value;
  logic [NUM_CDB_SRC-1:0][ROB_W-1:0]  src_rob_tag;

  logic [CDB_W-1:0]                   cdb_valid;
  logic [CDB_W-1:0][PHYS_W-1:0]       cdb_tag;
  logic [CDB_W-1:0][63:0]             cdb_value;
  logic [CDB_W-1:0][ROB_W-1:0]        cdb_rob_tag;

  modport master (
    output src_valid, src_tag, src_value, src_rob_tag,
    input  src_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
  );

  modport slave (
    input  src_valid, src_tag, src_value, src_rob_tag,
    output src_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
  );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// In-order result buffer for one execution-unit source.
// Ports:
//   clk, reset (sync, active-low), flush (sync, empties the buffer)
//   push, pkt_in   write a packet; ignored when full
//   pop            drop the head; ignored when empty
//   head           oldest packet (valid when !empty)
//   count, full, empty   occupancy status
module cdb_arbiter_result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W_L = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  cdb_pkt_t           pkt_in,
  input  logic               pop,
  output cdb_pkt_t           head,
  output logic [CNT_W_L-1:0] count,
  output logic               full,
  output logic               empty
);

  cdb_pkt_t           mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W_L-1:0] count_r;
  logic               push_s;
  logic               pop_s;

  assign full   = (count_r == CNT_W_L'(DEPTH));
  assign empty  = (count_r == {CNT_W_L{1'b0}});
  assign count  = count_r;
  assign head   = mem_r[rd_ptr_r];
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;

  // Payload storage; a write dropped by flush is harmless because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= pkt_in;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W_L{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W_L{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W_L'(1);
        2'b01:   count_r <= count_r - CNT_W_L'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter.
// Buffers results from NUM_CDB_SRC execution units (one FIFO per source) and
// broadcasts up to CDB_W of them per cycle on registered cdb_* outputs.
// Grants are round-robin, starting the scan at rr_ptr.
// Ports:
//   clk    clock
//   reset  synchronous, active-low reset
//   flush  synchronous pipeline flush; empties all buffers, keeps rr_ptr
//   bus    cdb_arbiter_if.slave (src_* handshake in, cdb_* broadcast out)
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  cdb_pkt_t               pkt_in_s  [NUM_CDB_SRC];
  cdb_pkt_t               head_s    [NUM_CDB_SRC];
  logic [CNT_W-1:0]       count_s   [NUM_CDB_SRC];
  logic [NUM_CDB_SRC-1:0] full_s;
  logic [NUM_CDB_SRC-1:0] empty_s;
  logic [NUM_CDB_SRC-1:0] push_s;
  logic [NUM_CDB_SRC-1:0] grant_s;
  logic [NUM_CDB_SRC-1:0] avail_s;
  logic [NUM_CDB_SRC-1:0] ready_s;
  logic [SRC_W-1:0]       scan_idx_s;
  logic [SRC_W-1:0]       lane_src_s [CDB_W];
  logic [CDB_W-1:0]       lane_vld_s;
  logic [SRC_W-1:0]       rr_next_s;

  logic [SRC_W-1:0]       rr_ptr_r;
  logic [CDB_W-1:0]       cdb_valid_r;
  cdb_pkt_t               lane_pkt_r [CDB_W];

  // Pack incoming payloads and derive ready from occupancy alone (not pop-aware).
  always_comb begin
    for (int i = 0; i < NUM_CDB_SRC; i++) begin
      pkt_in_s[i] = '{
        tag:     bus.src_tag[i],
        value:   bus.src_value[i],
        rob_tag: bus.src_rob_tag[i]
      };
      ready_s[i] = (count_s[i] != CNT_W'(FIFO_DEPTH));
    end
  end

  assign bus.src_ready = ready_s;
  assign push_s        = bus.src_valid & ~full_s;

  for (genvar i = 0; i < NUM_CDB_SRC; i++) begin : g_src
    cdb_arbiter_result_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .push   (push_s[i]),
      .pkt_in (pkt_in_s[i]),
      .pop    (grant_s[i]),
      .head   (head_s[i]),
      .count  (count_s[i]),
      .full   (full_s[i]),
      .empty  (empty_s[i])
    );
  end

  // Round-robin scan: each lane in turn takes the next non-empty, not yet granted
  // source in order rr_ptr, rr_ptr+1, ...
  // Lanes therefore fill from lane 0, and the pointer moves past the last source granted.
  always_comb begin
    avail_s    = ~empty_s;
    grant_s    = {NUM_CDB_SRC{1'b0}};
    lane_vld_s = {CDB_W{1'b0}};
    rr_next_s  = rr_ptr_r;
    scan_idx_s = {SRC_W{1'b0}};
    for (int k = 0; k < CDB_W; k++) begin
      lane_src_s[k] = {SRC_W{1'b0}};
      for (int j = 0; j < NUM_CDB_SRC; j++) begin
        scan_idx_s = src_step(rr_ptr_r, j);
        if (!lane_vld_s[k] && avail_s[scan_idx_s]) begin
          lane_vld_s[k]       = 1'b1;
          lane_src_s[k]       = scan_idx_s;
          avail_s[scan_idx_s] = 1'b0;
          grant_s[scan_idx_s] = 1'b1;
          rr_next_s           = src_step(scan_idx_s, 1);
        end else begin
          lane_vld_s[k] = lane_vld_s[k];
        end
      end
    end
  end

  // Broadcast registers and rr_ptr.
  // Flush drops valids but keeps rr_ptr.
  // Ungranted lanes keep their old payload.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cdb_valid_r <= {CDB_W{1'b0}};
      rr_ptr_r    <= {SRC_W{1'b0}};
      for (int k = 0; k < CDB_W; k++) begin
        lane_pkt_r[k] <= CDB_PKT_ZERO;
      end
    end else if (flush) begin
      cdb_valid_r <= {CDB_W{1'b0}};
    end else begin
      cdb_valid_r <= lane_vld_s;
      rr_ptr_r    <= rr_next_s;
      for (int k = 0; k < CDB_W; k++) begin
        if (lane_vld_s[k]) begin
          lane_pkt_r[k] <= head_s[lane_src_s[k]];
        end
      end
    end
  end

  assign bus.cdb_valid = cdb_valid_r;

  // Unpack the lane registers onto the broadcast bus.
  always_comb begin
    for (int k = 0; k < CDB_W; k++) begin
      bus.cdb_tag[k]     = lane_pkt_r[k].tag;
      bus.cdb_value[k]   = lane_pkt_r[k].value;
      bus.cdb_rob_tag[k] = lane_pkt_r[k].rob_tag;
    end
  end

endmodule
